soc_bus_decoder: RTL and testbench

- Sits directly downstream of the CPU instr/data RAM arbiter.
- Accepts the arbiter's unified single-master request bus (req/gnt/rvalid, OBI-style).
- Decodes the address onto one of two slave ports: on-chip RAM or the peripheral region.
- Generates an error response for unmapped addresses and for slaves that never answer, so the arbiter's bus always frees.

---
 rtl/soc_bus_pkg.sv | 19 +
 rtl/soc_addr_region_match.sv | 14 +
 rtl/soc_bus_decoder.sv | 172 +++++++++++++++++
 tb/tb_soc_bus_decoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC bus decoder.
// Targets, FSM states and the error-response read data.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_PERIPH
    } bus_target_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } decoder_state_t;

    localparam logic [31:0] SOC_ERR_RDATA = 32'hBADC_AB1E;

endpackage

// File: rtl/soc_addr_region_match.sv
// Region hit compare: the address lies in [base, base + 2**size_log2).
// The base must be aligned to the region size.
module soc_addr_region_match #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE       = '0,
    parameter int unsigned            SIZE_LOG2  = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit
);

    assign hit = ((addr ^ BASE) >> SIZE_LOG2) == '0;

endmodule

// File: rtl/soc_bus_decoder.sv
// Single-master OBI-style decoder onto RAM and peripheral ports, with an
// error response for unmapped addresses and for slaves that never answer.
module soc_bus_decoder
    import soc_bus_pkg::*;
#(
    parameter int unsigned                SOC_ADDR_WIDTH   = 32,
    parameter logic [SOC_ADDR_WIDTH-1:0]  RAM_BASE         = '0,
    parameter int unsigned                RAM_SIZE_LOG2    = 16,
    parameter logic [SOC_ADDR_WIDTH-1:0]  PERIPH_BASE      = SOC_ADDR_WIDTH'(32'h1000_0000),
    parameter int unsigned                PERIPH_SIZE_LOG2 = 12,
    parameter int unsigned                TIMEOUT_CYCLES   = 64,
    parameter logic [31:0]                ERR_RDATA        = SOC_ERR_RDATA
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      soc_req_i,
    input  logic [SOC_ADDR_WIDTH-1:0] soc_addr_i,
    input  logic [3:0]                soc_be_i,
    input  logic                      soc_we_i,
    input  logic [31:0]               soc_wdata_i,
    output logic                      soc_gnt_o,
    output logic                      soc_rvalid_o,
    output logic [31:0]               soc_rdata_o,
    output logic                      soc_err_o,
    output logic                      ram_req_o,
    output logic [SOC_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [3:0]                ram_be_o,
    output logic                      ram_we_o,
    output logic [31:0]               ram_wdata_o,
    input  logic                      ram_gnt_i,
    input  logic                      ram_rvalid_i,
    input  logic [31:0]               ram_rdata_i,
    output logic                      periph_req_o,
    output logic [SOC_ADDR_WIDTH-1:0] periph_addr_o,
    output logic [3:0]                periph_be_o,
    output logic                      periph_we_o,
    output logic [31:0]               periph_wdata_o,
    input  logic                      periph_gnt_i,
    input  logic                      periph_rvalid_i,
    input  logic [31:0]               periph_rdata_i,
    output logic [7:0]                timeout_cnt_o
);

    localparam int unsigned        TimerW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0]  TimerOne  = TimerW'(1);
    localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    decoder_state_t     state_q;
    bus_target_t        target_q;
    logic [TimerW-1:0]  timer_q;
    logic [7:0]         timeout_cnt_q;

    logic        hit_ram, hit_periph;
    logic        sel_ram, sel_periph;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    soc_addr_region_match #(
        .ADDR_WIDTH (SOC_ADDR_WIDTH),
        .BASE       (RAM_BASE),
        .SIZE_LOG2  (RAM_SIZE_LOG2)
    ) u_ram_match (
        .addr (soc_addr_i),
        .hit  (hit_ram)
    );

    soc_addr_region_match #(
        .ADDR_WIDTH (SOC_ADDR_WIDTH),
        .BASE       (PERIPH_BASE),
        .SIZE_LOG2  (PERIPH_SIZE_LOG2)
    ) u_periph_match (
        .addr (soc_addr_i),
        .hit  (hit_periph)
    );

    always_comb begin
        sel_ram    = 1'b0;
        sel_periph = 1'b0;
        gnt        = 1'b0;
        rvalid     = 1'b0;
        err        = 1'b0;
        rdata      = '0;
        unique case (state_q)
            IDLE: begin
                if (soc_req_i) begin
                    sel_ram    = hit_ram;
                    sel_periph = !hit_ram && hit_periph;
                    gnt        = hit_ram    ? ram_gnt_i    :
                                 hit_periph ? periph_gnt_i : 1'b1;
                end
            end
            WAIT: begin
                if (target_q == TGT_RAM) begin
                    rvalid = ram_rvalid_i;
                    rdata  = ram_rdata_i;
                end else if (target_q == TGT_PERIPH) begin
                    rvalid = periph_rvalid_i;
                    rdata  = periph_rdata_i;
                end
            end
            ERR: begin
                rvalid = 1'b1;
                rdata  = ERR_RDATA;
                err    = 1'b1;
            end
            default: ;
        endcase
    end

    // The timer counts cycles since the grant, so the grant cycle itself loads 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            target_q      <= TGT_NONE;
            timer_q       <= '0;
            timeout_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sel_ram && ram_gnt_i) begin
                        target_q <= TGT_RAM;
                        timer_q  <= TimerOne;
                        state_q  <= WAIT;
                    end else if (sel_periph && periph_gnt_i) begin
                        target_q <= TGT_PERIPH;
                        timer_q  <= TimerOne;
                        state_q  <= WAIT;
                    end else if (soc_req_i && !hit_ram && !hit_periph) begin
                        state_q <= ERR;
                    end
                end
                WAIT: begin
                    if (rvalid) begin
                        target_q <= TGT_NONE;
                        state_q  <= IDLE;
                    end else if (timer_q == TimerLast) begin
                        target_q <= TGT_NONE;
                        state_q  <= ERR;
                        if (timeout_cnt_q != 8'hFF) begin
                            timeout_cnt_q <= timeout_cnt_q + 8'd1;
                        end
                    end else begin
                        timer_q <= timer_q + TimerOne;
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, even with the master requesting.
    assign soc_gnt_o      = rst_ni & gnt;
    assign soc_rvalid_o   = rst_ni & rvalid;
    assign soc_err_o      = rst_ni & err;
    assign soc_rdata_o    = rst_ni ? rdata : '0;

    assign ram_req_o      = rst_ni & sel_ram;
    assign ram_addr_o     = ram_req_o ? soc_addr_i  : '0;
    assign ram_be_o       = ram_req_o ? soc_be_i    : '0;
    assign ram_we_o       = ram_req_o & soc_we_i;
    assign ram_wdata_o    = ram_req_o ? soc_wdata_i : '0;

    assign periph_req_o   = rst_ni & sel_periph;
    assign periph_addr_o  = periph_req_o ? soc_addr_i  : '0;
    assign periph_be_o    = periph_req_o ? soc_be_i    : '0;
    assign periph_we_o    = periph_req_o & soc_we_i;
    assign periph_wdata_o = periph_req_o ? soc_wdata_i : '0;

    assign timeout_cnt_o  = timeout_cnt_q;

endmodule

// File: tb/tb_soc_bus_decoder.sv
// Directed bench for soc_bus_decoder: responses are checked by a scoreboard
// monitor, cycle-level handshake properties are checked inline.
module tb_soc_bus_decoder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        soc_req_i;
    logic [31:0] soc_addr_i;
    logic [3:0]  soc_be_i;
    logic        soc_we_i;
    logic [31:0] soc_wdata_i;
    logic        soc_gnt_o, soc_rvalid_o, soc_err_o;
    logic [31:0] soc_rdata_o;
    logic        ram_req_o, ram_we_o, periph_req_o, periph_we_o;
    logic [31:0] ram_addr_o, ram_wdata_o, periph_addr_o, periph_wdata_o;
    logic [3:0]  ram_be_o, periph_be_o;
    logic        ram_gnt_i, ram_rvalid_i, periph_gnt_i, periph_rvalid_i;
    logic [31:0] ram_rdata_i, periph_rdata_i;
    logic [7:0]  timeout_cnt_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    soc_bus_decoder #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .soc_req_i       (soc_req_i),
        .soc_addr_i      (soc_addr_i),
        .soc_be_i        (soc_be_i),
        .soc_we_i        (soc_we_i),
        .soc_wdata_i     (soc_wdata_i),
        .soc_gnt_o       (soc_gnt_o),
        .soc_rvalid_o    (soc_rvalid_o),
        .soc_rdata_o     (soc_rdata_o),
        .soc_err_o       (soc_err_o),
        .ram_req_o       (ram_req_o),
        .ram_addr_o      (ram_addr_o),
        .ram_be_o        (ram_be_o),
        .ram_we_o        (ram_we_o),
        .ram_wdata_o     (ram_wdata_o),
        .ram_gnt_i       (ram_gnt_i),
        .ram_rvalid_i    (ram_rvalid_i),
        .ram_rdata_i     (ram_rdata_i),
        .periph_req_o    (periph_req_o),
        .periph_addr_o   (periph_addr_o),
        .periph_be_o     (periph_be_o),
        .periph_we_o     (periph_we_o),
        .periph_wdata_o  (periph_wdata_o),
        .periph_gnt_i    (periph_gnt_i),
        .periph_rvalid_i (periph_rvalid_i),
        .periph_rdata_i  (periph_rdata_i),
        .timeout_cnt_o   (timeout_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic err, input string name);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        soc_req_i       = 1'b0;
        soc_addr_i      = '0;
        soc_be_i        = '0;
        soc_we_i        = 1'b0;
        soc_wdata_i     = '0;
        ram_gnt_i       = 1'b0;
        ram_rvalid_i    = 1'b0;
        ram_rdata_i     = '0;
        periph_gnt_i    = 1'b0;
        periph_rvalid_i = 1'b0;
        periph_rdata_i  = '0;
    endtask

    task automatic master_req(input logic [31:0] addr, input logic we,
                              input logic [3:0] be, input logic [31:0] wdata);
        soc_req_i   = 1'b1;
        soc_addr_i  = addr;
        soc_we_i    = we;
        soc_be_i    = be;
        soc_wdata_i = wdata;
    endtask

    // Scoreboard monitor: every response presented to the master must be expected.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (soc_rvalid_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stray_rvalid: got rdata=%h err=%b, expected no response",
                             soc_rdata_o, soc_err_o);
                end else begin
                    e = exp_q.pop_front();
                    if (soc_rdata_o !== e.rdata || soc_err_o !== e.err) begin
                        failures++;
                        $display("FAIL %s: got rdata=%h err=%b, expected rdata=%h err=%b",
                                 e.name, soc_rdata_o, soc_err_o, e.rdata, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected $finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        // Master requesting during reset must not leak onto any port.
        master_req(32'h0000_0040, 1'b0, 4'hF, 32'h0);
        ram_gnt_i = 1'b1;
        step();
        @(negedge clk_i);
        chk("reset_gnt", {31'b0, soc_gnt_o}, 32'd0);
        chk("reset_ram_req", {31'b0, ram_req_o}, 32'd0);
        chk("reset_rvalid", {31'b0, soc_rvalid_o}, 32'd0);
        chk("reset_timeout_cnt", {24'b0, timeout_cnt_o}, 32'd0);
        step();
        idle_inputs();
        rst_ni = 1'b1;
        step();

        // RAM read, 1-cycle slave.
        master_req(32'h0000_0100, 1'b0, 4'hF, 32'h0);
        ram_gnt_i = 1'b1;
        expect_rsp(32'h1111_2222, 1'b0, "ram_read_rsp");
        @(negedge clk_i);
        chk("ram_read_gnt", {31'b0, soc_gnt_o}, 32'd1);
        chk("ram_read_req", {31'b0, ram_req_o}, 32'd1);
        chk("ram_read_addr", ram_addr_o, 32'h0000_0100);
        chk("ram_read_no_periph", {31'b0, periph_req_o}, 32'd0);
        step();
        idle_inputs();
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'h1111_2222;
        @(negedge clk_i);
        chk("ram_read_latency", {31'b0, soc_rvalid_o}, 32'd1);
        chk("ram_read_no_periph2", {31'b0, periph_req_o}, 32'd0);
        step();
        idle_inputs();

        // Peripheral write, grant delayed 3 cycles.
        master_req(32'h1000_0004, 1'b1, 4'b0011, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("pw_req_held", {31'b0, periph_req_o}, 32'd1);
            chk("pw_payload", periph_wdata_o, 32'hCAFE_F00D);
            chk("pw_be_we", {27'b0, periph_be_o, periph_we_o}, {27'b0, 4'b0011, 1'b1});
            chk("pw_addr", periph_addr_o, 32'h1000_0004);
            chk("pw_no_gnt", {31'b0, soc_gnt_o}, 32'd0);
            chk("pw_ram_quiet", {ram_req_o, ram_wdata_o[30:0]}, 32'd0);
            step();
        end
        periph_gnt_i = 1'b1;
        expect_rsp(32'h0, 1'b0, "periph_write_rsp");
        @(negedge clk_i);
        chk("pw_gnt", {31'b0, soc_gnt_o}, 32'd1);
        step();
        idle_inputs();
        periph_rvalid_i = 1'b1;
        step();
        idle_inputs();

        // Unmapped read: same-cycle grant, error one cycle later.
        master_req(32'h2000_0000, 1'b0, 4'hF, 32'h0);
        expect_rsp(32'hBADC_AB1E, 1'b1, "unmapped_rsp");
        @(negedge clk_i);
        chk("unmapped_gnt", {31'b0, soc_gnt_o}, 32'd1);
        chk("unmapped_no_slave", {30'b0, ram_req_o, periph_req_o}, 32'd0);
        step();
        idle_inputs();
        @(negedge clk_i);
        chk("unmapped_rvalid", {31'b0, soc_rvalid_o}, 32'd1);
        step();

        // Silent RAM slave: error 4 cycles after grant, late rvalid dropped.
        master_req(32'h0000_0080, 1'b0, 4'hF, 32'h0);
        ram_gnt_i = 1'b1;
        expect_rsp(32'hBADC_AB1E, 1'b1, "timeout_rsp");
        step();
        idle_inputs();
        for (int i = 1; i < 4; i++) begin
            @(negedge clk_i);
            chk("timeout_quiet", {31'b0, soc_rvalid_o}, 32'd0);
            step();
        end
        @(negedge clk_i);
        chk("timeout_rvalid", {31'b0, soc_rvalid_o}, 32'd1);
        chk("timeout_cnt", {24'b0, timeout_cnt_o}, 32'd1);
        step();
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'h0BAD_0BAD;
        @(negedge clk_i);
        chk("late_rvalid_dropped", {31'b0, soc_rvalid_o}, 32'd0);
        step();
        idle_inputs();

        // Back-to-back: RAM read then peripheral read, no overlap.
        master_req(32'h0000_0200, 1'b0, 4'hF, 32'h0);
        ram_gnt_i = 1'b1;
        expect_rsp(32'h1234_5678, 1'b0, "b2b_ram_rsp");
        step();
        idle_inputs();
        master_req(32'h1000_0010, 1'b0, 4'hF, 32'h0);
        periph_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("b2b_wait_gnt", {30'b0, soc_gnt_o, periph_req_o}, 32'd0);
        step();
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'h1234_5678;
        @(negedge clk_i);
        chk("b2b_rvalid_gnt", {30'b0, soc_gnt_o, periph_req_o}, 32'd0);
        step();
        ram_rvalid_i = 1'b0;
        expect_rsp(32'h5555_AAAA, 1'b0, "b2b_periph_rsp");
        @(negedge clk_i);
        chk("b2b_second_gnt", {30'b0, soc_gnt_o, periph_req_o}, 32'd3);
        step();
        idle_inputs();
        periph_rvalid_i = 1'b1;
        periph_rdata_i  = 32'h5555_AAAA;
        step();
        idle_inputs();

        // Reset while in WAIT: everything quiet at once, then a normal read.
        master_req(32'h0000_0300, 1'b0, 4'hF, 32'h0);
        ram_gnt_i = 1'b1;
        step();
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'hDEAD_DEAD;
        rst_ni       = 1'b0;
        @(negedge clk_i);
        chk("rst_wait_rsp", {29'b0, soc_gnt_o, soc_rvalid_o, soc_err_o}, 32'd0);
        chk("rst_wait_rdata", soc_rdata_o, 32'd0);
        chk("rst_wait_slaves", {30'b0, ram_req_o, periph_req_o}, 32'd0);
        chk("rst_wait_cnt", {24'b0, timeout_cnt_o}, 32'd0);
        step();
        idle_inputs();
        rst_ni = 1'b1;
        step();
        master_req(32'h0000_0204, 1'b0, 4'hF, 32'h0);
        ram_gnt_i = 1'b1;
        expect_rsp(32'h600D_F00D, 1'b0, "post_reset_rsp");
        @(negedge clk_i);
        chk("post_reset_gnt", {31'b0, soc_gnt_o}, 32'd1);
        step();
        idle_inputs();
        @(negedge clk_i);
        chk("post_reset_quiet", {31'b0, soc_rvalid_o}, 32'd0);
        step();
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'h600D_F00D;
        step();
        idle_inputs();
        step();
        step();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
